// File: rtl/audio_adc_rx.sv
// audio_adc_rx: capture end of the CODEC serial interface.
// Oversamples AUD_BCLK / AUD_ADCLRCK / AUD_ADCDAT on CLOCK_50. It deserialises
// I2S stereo slots (one delay bit after each LRCK change, then MSB first) into
// parallel two's-complement samples, and presents each left/right pair with a
// one-cycle strobe.
//
// Ports:
//   CLOCK_50      system clock, all logic on the rising edge
//   reset         asynchronous active-low reset
//   aud_bclk      CODEC bit clock (asynchronous, synchronised here)
//   aud_adclrck   ADC LR clock, 0 = left slot, 1 = right slot
//   aud_adcdat    ADC serial data
//   peak_clr      clears the peak register (peak build only)
//   left_sample   last complete left word
//   right_sample  last complete right word
//   sample_valid  one-cycle pulse, new pair on left_sample/right_sample
//   frame_err     one-cycle pulse, slot ended before DATA_WIDTH bits arrived
//   peak          peak magnitude since last clear
//
// Build option: define AUDIO_RX_PEAK_EN to include the peak-magnitude tracker.
// Without it, peak is tied to 0 and peak_clr is ignored.

module audio_adc_rx #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  aud_bclk,
  input  logic                  aud_adclrck,
  input  logic                  aud_adcdat,
  input  logic                  peak_clr,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  output logic                  frame_err,
  output logic [DATA_WIDTH-2:0] peak
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StArm, StShift, StWait} state_e;

  // [0],[1] are the synchroniser; [2] is the edge register. lrck/dat share the
  // same depth so that their stage [2] lines up with rise_q.
  logic [2:0] bclk_pipe_q, lrck_pipe_q, dat_pipe_q;
  logic       rise_q;
  logic       lrck_s, dat_s;

  state_e                state_q, state_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic                  chan_q, chan_d;
  logic [CntW-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  left_ok_q, left_ok_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  changed;
  logic                  start_slot;
  logic [DATA_WIDTH-1:0] word;

  assign lrck_s = lrck_pipe_q[2];
  assign dat_s  = dat_pipe_q[2];

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bclk_pipe_q <= '0;
      lrck_pipe_q <= '0;
      dat_pipe_q  <= '0;
      rise_q      <= 1'b0;
    end else begin
      bclk_pipe_q <= {bclk_pipe_q[1:0], aud_bclk};
      lrck_pipe_q <= {lrck_pipe_q[1:0], aud_adclrck};
      dat_pipe_q  <= {dat_pipe_q[1:0], aud_adcdat};
      rise_q      <= bclk_pipe_q[1] & ~bclk_pipe_q[2];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StArm;
      lrck_prev_q <= 1'b0;
      chan_q      <= 1'b0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lrck_prev_q <= lrck_prev_d;
      chan_q      <= chan_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lrck_prev_d = lrck_prev_q;
    chan_d      = chan_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    start_slot  = 1'b0;
    changed     = (lrck_s != lrck_prev_q);
    word        = {shreg_q, dat_s};

    if (rise_q) begin
      lrck_prev_d = lrck_s;
      unique case (state_q)
        StArm, StWait: start_slot = changed;
        StShift: begin
          if (changed) begin
            // Short slot: drop the partial word and restart on this delay bit.
            err_d      = 1'b1;
            start_slot = 1'b1;
          end else begin
            shreg_d  = word[DATA_WIDTH-2:0];
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == LastBit) begin
              state_d = StWait;
              if (!chan_q) begin
                left_hold_d = word;
                left_ok_d   = 1'b1;
              end else begin
                if (left_ok_q) begin
                  left_d  = left_hold_q;
                  right_d = word;
                  valid_d = 1'b1;
                end
                left_ok_d = 1'b0;
              end
            end
          end
        end
        default: state_d = StArm;
      endcase

      // The rise that sees the LRCK change is the I2S delay bit; nothing shifted.
      if (start_slot) begin
        chan_d   = lrck_s;
        bitcnt_d = '0;
        state_d  = StShift;
        // A new left slot must complete before the next right can form a pair.
        if (!lrck_s) begin
          left_ok_d = 1'b0;
        end
      end
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

`ifdef AUDIO_RX_PEAK_EN
  logic [DATA_WIDTH-2:0] peak_q, peak_d;
  logic [DATA_WIDTH-2:0] mag_l, mag_r;

  // |v| in DATA_WIDTH-1 bits; the most negative value saturates to all ones.
  function automatic logic [DATA_WIDTH-2:0] magnitude(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-2:0] low;
    low = v[DATA_WIDTH-2:0];
    if (!v[DATA_WIDTH-1]) begin
      return low;
    end else if (low == '0) begin
      return '1;
    end else begin
      return ~low + 1'b1;
    end
  endfunction

  always_comb begin
    mag_l  = magnitude(left_q);
    mag_r  = magnitude(right_q);
    peak_d = peak_clr ? '0 : peak_q;
    // Clear only discards the old peak; a coincident pair still loads.
    if (valid_q) begin
      if (mag_l > peak_d) begin
        peak_d = mag_l;
      end
      if (mag_r > peak_d) begin
        peak_d = mag_r;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak = '0;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// Self-checking bench for audio_adc_rx. A slot-level I2S model predicts the
// pairs, frame errors and peak; a negedge compare process checks the DUT.

module tb_audio_adc_rx;

  localparam int W = 16;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          aud_bclk = 1'b0;
  logic          aud_adclrck = 1'b0;
  logic          aud_adcdat = 1'b0;
  logic          peak_clr = 1'b0;
  logic [W-1:0]  left_sample, right_sample;
  logic          sample_valid, frame_err;
  logic [W-2:0]  peak;

  audio_adc_rx #(.DATA_WIDTH(W)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .aud_bclk    (aud_bclk),
    .aud_adclrck (aud_adclrck),
    .aud_adcdat  (aud_adcdat),
    .peak_clr    (peak_clr),
    .left_sample (left_sample),
    .right_sample(right_sample),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .peak        (peak)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slot-level model ----------------
  bit            m_prev = 1'b0;
  bit            m_pending_short = 1'b0;
  bit            m_left_ok = 1'b0;
  logic [W-1:0]  m_left = '0;
  logic [31:0]   exp_q[$];
  int            exp_err = 0;
  int            got_err = 0;
  int            got_valid = 0;
  logic [W-2:0]  exp_peak = '0;

  function automatic logic [W-2:0] mag(input logic [W-1:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return 15'(v);
  endfunction

  // A slot of n rises: rise 0 is the delay bit, rises 1..W carry the word.
  function automatic void model_slot(input bit l, input logic [W-1:0] w, input int n);
    if (l != m_prev) begin
      if (m_pending_short) exp_err++;
      m_pending_short = 1'b0;
      m_prev = l;
      if (!l) m_left_ok = 1'b0;
      if (n - 1 >= W) begin
        if (!l) begin
          m_left    = w;
          m_left_ok = 1'b1;
        end else begin
          if (m_left_ok) exp_q.push_back({m_left, w});
          m_left_ok = 1'b0;
        end
      end else begin
        m_pending_short = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_prev = 1'b0;
    m_pending_short = 1'b0;
    m_left_ok = 1'b0;
    m_left = '0;
    exp_q.delete();
    exp_err = 0;
    got_err = 0;
  endfunction

  // ---------------- compare process ----------------
  logic [W-1:0] hold_l = '0, hold_r = '0;
  bit           prev_valid = 1'b0, prev_err = 1'b0;

  always @(negedge CLOCK_50) begin
    logic [31:0]  e;
    logic [W-2:0] nx;
    if (!reset) begin
      check("rst_left", left_sample, '0);
      check("rst_right", right_sample, '0);
      check("rst_valid", sample_valid, 0);
      check("rst_err", frame_err, 0);
      check("rst_peak", peak, '0);
      hold_l = '0;
      hold_r = '0;
      exp_peak = '0;
    end else begin
      check("peak", peak, exp_peak);
      nx = peak_clr ? '0 : exp_peak;
      if (sample_valid) begin
        got_valid++;
        check("valid_width", prev_valid, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got sample_valid=1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("pair_left", left_sample, e[31:16]);
          check("pair_right", right_sample, e[15:0]);
          hold_l = e[31:16];
          hold_r = e[15:0];
          if (mag(e[31:16]) > nx) nx = mag(e[31:16]);
          if (mag(e[15:0]) > nx) nx = mag(e[15:0]);
        end
      end else begin
        check("hold_left", left_sample, hold_l);
        check("hold_right", right_sample, hold_r);
      end
`ifdef AUDIO_RX_PEAK_EN
      exp_peak = nx;
`endif
      if (frame_err) begin
        got_err++;
        check("err_width", prev_err, 0);
      end
    end
    prev_valid = sample_valid;
    prev_err   = frame_err;
  end

  // ---------------- stimulus ----------------
  task automatic drive_slot(input bit l, input logic [W-1:0] w, input int n, input bit pad);
    model_slot(l, w, n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      aud_bclk    = 1'b0;
      aud_adclrck = l;
      aud_adcdat  = (i == 0) ? 1'b0 : (i <= W) ? w[W-i] : pad;
      repeat (8) @(negedge CLOCK_50);
      aud_bclk = 1'b1;
      repeat (7) @(negedge CLOCK_50);
    end
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50);
    #2;
    reset       = 1'b0;
    aud_bclk    = 1'b0;
    aud_adclrck = 1'b0;
    aud_adcdat  = 1'b0;
    #1;
    check("async_rst_left", left_sample, '0);
    check("async_rst_right", right_sample, '0);
    model_reset();
    repeat (4) @(posedge CLOCK_50);
    #2;
    reset = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic phase_end(input string name);
    repeat (20) @(negedge CLOCK_50);
    check({name, "_pending_pairs"}, exp_q.size(), 0);
    check({name, "_frame_errs"}, got_err, exp_err);
  endtask

  task automatic pulse_clr();
    @(posedge CLOCK_50);
    #1 peak_clr = 1'b1;
    @(posedge CLOCK_50);
    #1 peak_clr = 1'b0;
    repeat (3) @(negedge CLOCK_50);
  endtask

  initial begin
    int v0;
    #2 reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_valid", sample_valid, 0);
    check("reset_peak", peak, '0);
    @(posedge CLOCK_50);
    #2 reset = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    // Basic frame, preceded by a right slot to leave ARM.
    v0 = got_valid;
    drive_slot(1'b1, 16'hAAAA, 32, 1'b0);
    drive_slot(1'b0, 16'h1234, 32, 1'b0);
    drive_slot(1'b1, 16'hEDCB, 32, 1'b0);
    phase_end("basic");
    check("basic_left", left_sample, 16'h1234);
    check("basic_right", right_sample, 16'hEDCB);
    check("basic_valid_count", got_valid - v0, 1);

    // Trailing slot bits driven high must not leak in.
    drive_slot(1'b0, 16'h8001, 32, 1'b1);
    drive_slot(1'b1, 16'h7FFF, 32, 1'b1);
    phase_end("trailing");
    check("trail_left", left_sample, 16'h8001);
    check("trail_right", right_sample, 16'h7FFF);

    // Stream starting mid right slot after reset.
    do_reset();
    drive_slot(1'b1, 16'hFFFF, 8, 1'b0);
    drive_slot(1'b0, 16'h5A5A, 32, 1'b0);
    drive_slot(1'b1, 16'h3C3C, 32, 1'b0);
    phase_end("midslot");
    check("mid_left", left_sample, 16'h5A5A);
    check("mid_right", right_sample, 16'h3C3C);

    // Truncated left slot.
    v0 = got_valid;
    drive_slot(1'b0, 16'h1111, 10, 1'b0);
    drive_slot(1'b1, 16'h2222, 32, 1'b0);
    phase_end("short_left");
    check("short_no_valid", got_valid - v0, 0);
    drive_slot(1'b0, 16'h4321, 32, 1'b0);
    drive_slot(1'b1, 16'h8765, 32, 1'b0);
    phase_end("after_short");
    check("short_left_val", left_sample, 16'h4321);
    check("short_right_val", right_sample, 16'h8765);

    // Reset during the right slot, then resume.
    drive_slot(1'b0, 16'hABCD, 32, 1'b0);
    drive_slot(1'b1, 16'h6666, 9, 1'b0);
    do_reset();
    drive_slot(1'b1, 16'h9999, 23, 1'b0);
    drive_slot(1'b0, 16'h0F0F, 32, 1'b0);
    drive_slot(1'b1, 16'hF0F0, 32, 1'b0);
    phase_end("reset_mid");
    check("rm_left", left_sample, 16'h0F0F);
    check("rm_right", right_sample, 16'hF0F0);

    // Peak tracking.
    pulse_clr();
    check("peak_cleared", peak, '0);
    drive_slot(1'b0, 16'h0100, 32, 1'b0);
    drive_slot(1'b1, 16'hFF00, 32, 1'b0);
    phase_end("peak1");
`ifdef AUDIO_RX_PEAK_EN
    check("peak_0100", peak, 15'h0100);
`else
    check("peak_off1", peak, '0);
`endif
    drive_slot(1'b0, 16'h8000, 32, 1'b0);
    drive_slot(1'b1, 16'h0000, 32, 1'b0);
    phase_end("peak2");
`ifdef AUDIO_RX_PEAK_EN
    check("peak_7fff", peak, 15'h7FFF);
`else
    check("peak_off2", peak, '0);
`endif
    pulse_clr();
    check("peak_clr_zero", peak, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
